// File: rtl/led_seq_pkg.sv
// Shared types, codes and channel-search helpers for the LED fade sequencer.
package led_seq_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int PWM_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_FADE_OUT = 2'd2,
    ST_NEXT     = 2'd3
  } seq_state_t;

  localparam logic [1:0] MODE_SINGLE   = 2'b00;
  localparam logic [1:0] MODE_LOOP     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] idx;
  } ch_hit_t;

  // Lowest set bit strictly above 'from'.
  function automatic ch_hit_t search_up(input logic [NUM_CH-1:0] mask,
                                        input logic [CH_W-1:0]   from);
    ch_hit_t hit;
    hit = '{found: 1'b0, idx: 3'd0};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((i > int'(from)) && mask[i]) begin
        hit.found = 1'b1;
        hit.idx   = 3'(i);
      end
    end
    return hit;
  endfunction

  // Highest set bit strictly below 'from'.
  function automatic ch_hit_t search_down(input logic [NUM_CH-1:0] mask,
                                          input logic [CH_W-1:0]   from);
    ch_hit_t hit;
    hit = '{found: 1'b0, idx: 3'd0};
    for (int i = 0; i < NUM_CH; i++) begin
      if ((i < int'(from)) && mask[i]) begin
        hit.found = 1'b1;
        hit.idx   = 3'(i);
      end
    end
    return hit;
  endfunction

  // Lowest set bit of the whole mask (0 when the mask is empty).
  function automatic logic [CH_W-1:0] search_lowest(input logic [NUM_CH-1:0] mask);
    logic [CH_W-1:0] idx;
    idx = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_fade_sequencer_pwm_gen.sv
// Free-running 8-bit PWM counter and duty comparator.
module pwm_gen
  import led_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] level,
  output logic             pwm_out
);

  logic [PWM_W-1:0] cnt_r;

  // Counter wraps 255 -> 0 on its own; level only moves the compare point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  assign pwm_out = (cnt_r < level);

endmodule

// File: rtl/led_fade_sequencer.sv
// Walks a set of LED channels, fading each one up to full and back to dark.
module led_fade_sequencer
  import led_seq_pkg::*;
#(
  parameter logic [15:0] STEP_DIV = 16'd4096,
  parameter int          PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                busy,
  output logic                done,
  output logic [NUM_CH-1:0]   led,
  output logic [CH_W-1:0]     cur_ch
);

  seq_state_t          state_r;
  logic [NUM_CH-1:0]   mask_r;
  logic [1:0]          mode_r;
  logic                dir_r;
  logic [PWM_BITS-1:0] level_r;
  logic [15:0]         presc_r;
  logic [CH_W-1:0]     cur_ch_r;
  logic                done_r;
  logic [NUM_CH-1:0]   led_r;

  logic                tick_s;
  logic                pwm_out_s;
  logic [NUM_CH-1:0]   pwm_vec_s;
  ch_hit_t             fwd_hit_s;
  ch_hit_t             rev_hit_s;
  logic [CH_W-1:0]     first_ch_s;
  logic [CH_W-1:0]     start_ch_s;

  pwm_gen u_pwm_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .level   (level_r),
    .pwm_out (pwm_out_s)
  );

  assign tick_s     = (presc_r == (STEP_DIV - 16'd1));
  assign pwm_vec_s  = {{(NUM_CH-1){1'b0}}, pwm_out_s} << cur_ch_r;
  assign first_ch_s = search_lowest(mask_r);
  assign start_ch_s = search_lowest(ch_mask);

  // Next-channel search in the current direction and, for ping-pong, the reverse one.
  always_comb begin
    fwd_hit_s = '0;
    rev_hit_s = '0;
    if (dir_r == DIR_UP) begin
      fwd_hit_s = search_up(mask_r, cur_ch_r);
      rev_hit_s = search_down(mask_r, cur_ch_r);
    end else begin
      fwd_hit_s = search_down(mask_r, cur_ch_r);
      rev_hit_s = search_up(mask_r, cur_ch_r);
    end
  end

  // Sequencer FSM: stop aborts any active state; led and done are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      mask_r   <= 8'd0;
      mode_r   <= MODE_SINGLE;
      dir_r    <= DIR_UP;
      level_r  <= 8'd0;
      presc_r  <= 16'd0;
      cur_ch_r <= 3'd0;
      done_r   <= 1'b0;
      led_r    <= 8'd0;
    end else begin
      done_r <= 1'b0;
      led_r  <= 8'd0;
      if (stop && (state_r != ST_IDLE)) begin
        state_r <= ST_IDLE;
        level_r <= 8'd0;
        presc_r <= 16'd0;
        done_r  <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start && !stop) begin
              if (ch_mask != 8'd0) begin
                mask_r   <= ch_mask;
                mode_r   <= (mode == 2'b11) ? MODE_SINGLE : mode;
                cur_ch_r <= start_ch_s;
                dir_r    <= DIR_UP;
                level_r  <= 8'd0;
                presc_r  <= 16'd0;
                state_r  <= ST_FADE_IN;
              end else begin
                done_r <= 1'b1;
              end
            end
          end
          ST_FADE_IN: begin
            led_r <= pwm_vec_s;
            if (tick_s) begin
              presc_r <= 16'd0;
              level_r <= level_r + 8'd1;
              if (level_r == 8'd254) begin
                state_r <= ST_FADE_OUT;
              end
            end else begin
              presc_r <= presc_r + 16'd1;
            end
          end
          ST_FADE_OUT: begin
            if (tick_s) begin
              presc_r <= 16'd0;
              level_r <= level_r - 8'd1;
              if (level_r == 8'd1) begin
                // Channel is dark: led stays at its default 0 through NEXT.
                state_r <= ST_NEXT;
              end else begin
                led_r <= pwm_vec_s;
              end
            end else begin
              led_r   <= pwm_vec_s;
              presc_r <= presc_r + 16'd1;
            end
          end
          ST_NEXT: begin
            presc_r <= 16'd0;
            level_r <= 8'd0;
            if (fwd_hit_s.found) begin
              cur_ch_r <= fwd_hit_s.idx;
              state_r  <= ST_FADE_IN;
            end else begin
              case (mode_r)
                MODE_LOOP: begin
                  cur_ch_r <= first_ch_s;
                  dir_r    <= DIR_UP;
                  state_r  <= ST_FADE_IN;
                end
                MODE_PINGPONG: begin
                  // A single-bit mask finds nothing either way and replays cur_ch.
                  dir_r    <= ~dir_r;
                  cur_ch_r <= rev_hit_s.found ? rev_hit_s.idx : cur_ch_r;
                  state_r  <= ST_FADE_IN;
                end
                default: begin
                  state_r <= ST_IDLE;
                  done_r  <= 1'b1;
                end
              endcase
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy   = (state_r != ST_IDLE);
  assign done   = done_r;
  assign led    = led_r;
  assign cur_ch = cur_ch_r;

endmodule
